mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported memory bus between instruction fetch (IF) and the
//  MEM-stage load/store path. Data requests win ties; a burst counter bounds IF starvation.
//  Performs store lane steering/byte enables and load-data lane alignment;
//  the MEM stage still does sign/zero extension. Sits between the pipeline and the memory.
//  Drives stallF_o/stallM_o while a requester waits.
// PARAMETERS
//  XLEN         32  data/address width (XLEN=32 only)
//  MAX_D_BURST  4   consecutive data grants allowed while IF is waiting (>=1)
// PORTS
//  clk_i         in   1     clock, rising edge
//  rstn_i        in   1     reset; asynchronous, active-low
//  if_req_i      in   1     fetch request, held until if_valid_o
//  if_addr_i     in   XLEN  fetch address (word aligned)
//  if_rdata_o    out  XLEN  fetched instruction word
//  if_valid_o    out  1     1-cycle pulse: if_rdata_o valid
//  dm_req_i      in   1     load/store request, held until dm_valid_o
//  dm_we_i       in   1     1=store, 0=load
//  dm_size_i     in   2     0=byte 1=half 2=word (3 treated as word)
//  dm_addr_i     in   XLEN  byte address
//  dm_wdata_i    in   XLEN  store data, LSB-justified
//  dm_rdata_o    out  XLEN  load data, shifted to LSB, upper bits unmasked
//  dm_valid_o    out  1     1-cycle pulse: data access complete
//  dm_err_o      out  1     with dm_valid_o: misaligned, no bus access made
//  stallF_o      out  1     if_req_i & ~if_valid_o
//  stallM_o      out  1     dm_req_i & ~dm_valid_o
//  mem_req_o     out  1     bus request, held until mem_gnt_i
//  mem_we_o      out  1     bus write
//  mem_be_o      out  4     byte enables
//  mem_addr_o    out  XLEN  word address ({addr[XLEN-1:2],2'b00})
//  mem_wdata_o   out  XLEN  lane-steered write data
//  mem_gnt_i     in   1     bus accepts request this cycle
//  mem_rvalid_i  in   1     response (read data or write ack)
//  mem_rdata_i   in   XLEN  read data word
// BEHAVIOUR
//  Reset: FSM=IDLE, burst cnt=0, all outputs 0 (stall outputs follow inputs).
//  FSM IDLE/REQ/WAIT/DONE; one outstanding transaction max.
//  IDLE: pick owner: dm_req_i if present, unless cnt==MAX_D_BURST & if_req_i -> IF.
//   Data grant with if_req_i pending: cnt++; IF grant or IF idle: cnt=0.
//   Misaligned data (half addr[0]=1, word addr[1:0]!=0): no bus cycle; ->DONE with err.
//   Else register addr/we/be/wdata, owner; next REQ (mem_req_o=1 next cycle).
//  REQ: hold mem_* stable until mem_gnt_i; gnt -> WAIT, gnt&rvalid same cycle -> DONE.
//  WAIT: mem_rvalid_i -> DONE capturing lane-aligned data; mem_req_o=0.
//  DONE: pulse owner valid (and dm_err_o if error) for 1 cycle -> IDLE.
//   Best-case latency req->valid: 3 cycles (IDLE, REQ+gnt, WAIT+rvalid, DONE pulse).
//  Byte enables: byte 4'b0001<<a[1:0]; half 4'b0011<<{a[1],1'b0}; word 4'b1111.
//  wdata: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
//  Load: dm_rdata_o = mem_rdata_i >> (8*a[1:0]); IF gets word unchanged.
//  Stores complete on mem_rvalid_i (write ack); dm_rdata_o=0 for stores.
//  mem_rvalid_i outside REQ/WAIT is ignored (no pulse, no state change).
//  Requester dropping req mid-transaction: transaction still completes, pulse still issued.
//  Async reset mid-transaction: immediate IDLE, mem_req_o drops; late rvalid ignored.
//  Valid pulses only in DONE; if_valid_o and dm_valid_o never high together.
// TESTING
//  Load word: dm_req addr=0x100, gnt next cycle, rvalid 1 later data 0xDEADBEEF
//   -> mem_be=0xF, addr=0x100, dm_rdata=0xDEADBEEF, dm_valid 3 cycles after req.
//  SB addr=0x203 data=0x55 -> mem_be=4'b1000, mem_wdata=0x55555555, addr=0x200, stallM until ack.
//  LH addr=0x12 rdata=0xABCD1234 -> dm_rdata=0x0000ABCD; SH addr=0x11 -> dm_err, no mem_req.
//  IF+data both requesting continuously, MAX_D_BURST=4 -> grant order D,D,D,D,I,D,D,D,D,I.
//  gnt held low 5 cycles -> mem_* stable all 5 cycles; gnt&rvalid same cycle -> DONE next.
//  rstn_i low in WAIT then rvalid after release -> no valid pulse, FSM IDLE, outputs 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-bus signals around mem_port_arbiter.
// slave is the arbiter's view; master is the pipeline-plus-memory side.
interface mem_port_arbiter_if #(
  parameter int XLEN = 32
);
  logic            if_req_i;
  logic [XLEN-1:0] if_addr_i;
  logic [XLEN-1:0] if_rdata_o;
  logic            if_valid_o;
  logic            dm_req_i;
  logic            dm_we_i;
  logic [1:0]      dm_size_i;
  logic [XLEN-1:0] dm_addr_i;
  logic [XLEN-1:0] dm_wdata_i;
  logic [XLEN-1:0] dm_rdata_o;
  logic            dm_valid_o;
  logic            dm_err_o;
  logic            stallF_o;
  logic            stallM_o;
  logic            mem_req_o;
  logic            mem_we_o;
  logic [3:0]      mem_be_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [XLEN-1:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_size_i, dm_addr_i, dm_wdata_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output if_rdata_o, if_valid_o, dm_rdata_o, dm_valid_o, dm_err_o, stallF_o, stallM_o,
           mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_size_i, dm_addr_i, dm_wdata_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  if_rdata_o, if_valid_o, dm_rdata_o, dm_valid_o, dm_err_o, stallF_o, stallM_o,
           mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and load/store,
// with data priority, a burst limit against fetch starvation, and byte-lane handling.
module mem_port_arbiter #(
  parameter int XLEN        = 32,
  parameter int MAX_D_BURST = 4
) (
  input logic              clk_i,
  input logic              rstn_i,
  mem_port_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_D_BURST + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t          state_q, state_n;
  logic            own_dm_q, own_dm_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [XLEN-1:0] addr_q, addr_n;
  logic [XLEN-1:0] wdata_q, wdata_n;
  logic [XLEN-1:0] rdata_q, rdata_n;
  logic            we_q, we_n;
  logic [3:0]      be_q, be_n;
  logic [1:0]      lane_q, lane_n;
  logic            err_q, err_n;

  logic            misaligned;
  logic [3:0]      dm_be;
  logic [XLEN-1:0] dm_wdata;
  logic            grant_dm;
  logic [XLEN-1:0] rsp_data;

  // Lane steering of the incoming data request, evaluated before it is granted.
  always_comb begin
    misaligned = 1'b0;
    dm_be      = 4'b1111;
    dm_wdata   = bus.dm_wdata_i;
    case (bus.dm_size_i)
      2'd0: begin
        dm_be    = 4'b0001 << bus.dm_addr_i[1:0];
        dm_wdata = {4{bus.dm_wdata_i[7:0]}};
      end
      2'd1: begin
        misaligned = bus.dm_addr_i[0];
        dm_be      = 4'b0011 << {bus.dm_addr_i[1], 1'b0};
        dm_wdata   = {2{bus.dm_wdata_i[15:0]}};
      end
      default: misaligned = |bus.dm_addr_i[1:0];
    endcase
  end

  assign grant_dm = bus.dm_req_i && !((cnt_q == CNT_W'(MAX_D_BURST)) && bus.if_req_i);

  always_comb begin
    rsp_data = '0;
    if (!we_q) rsp_data = own_dm_q ? (bus.mem_rdata_i >> {lane_q, 3'b000}) : bus.mem_rdata_i;
  end

  // NOTE: every next-value gets its hold default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n  = state_q;
    own_dm_n = own_dm_q;
    cnt_n    = cnt_q;
    addr_n   = addr_q;
    wdata_n  = wdata_q;
    rdata_n  = rdata_q;
    we_n     = we_q;
    be_n     = be_q;
    lane_n   = lane_q;
    err_n    = err_q;
    case (state_q)
      IDLE: begin
        err_n = 1'b0;
        if (grant_dm) begin
          own_dm_n = 1'b1;
          cnt_n    = bus.if_req_i ? cnt_q + CNT_W'(1) : '0;
          addr_n   = bus.dm_addr_i & ~XLEN'(3);
          we_n     = bus.dm_we_i;
          be_n     = dm_be;
          wdata_n  = dm_wdata;
          lane_n   = bus.dm_addr_i[1:0];
          rdata_n  = '0;
          // A misaligned access never reaches the bus; it just reports the error.
          if (misaligned) begin
            err_n   = 1'b1;
            state_n = DONE;
          end else begin
            state_n = REQ;
          end
        end else if (bus.if_req_i) begin
          own_dm_n = 1'b0;
          cnt_n    = '0;
          addr_n   = bus.if_addr_i & ~XLEN'(3);
          we_n     = 1'b0;
          be_n     = 4'b1111;
          wdata_n  = '0;
          lane_n   = 2'd0;
          rdata_n  = '0;
          state_n  = REQ;
        end else begin
          cnt_n = '0;
        end
      end
      REQ: begin
        if (bus.mem_gnt_i) begin
          if (bus.mem_rvalid_i) begin
            rdata_n = rsp_data;
            state_n = DONE;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.mem_rvalid_i) begin
          rdata_n = rsp_data;
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      own_dm_q <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      lane_q   <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      own_dm_q <= own_dm_n;
      cnt_q    <= cnt_n;
      addr_q   <= addr_n;
      wdata_q  <= wdata_n;
      rdata_q  <= rdata_n;
      we_q     <= we_n;
      be_q     <= be_n;
      lane_q   <= lane_n;
      err_q    <= err_n;
    end
  end

  // Bus fields are only driven while a request is actually on the bus.
  assign bus.mem_req_o   = (state_q == REQ);
  assign bus.mem_we_o    = (state_q == REQ) && we_q;
  assign bus.mem_be_o    = (state_q == REQ) ? be_q : 4'b0000;
  assign bus.mem_addr_o  = (state_q == REQ) ? addr_q : '0;
  assign bus.mem_wdata_o = (state_q == REQ) ? wdata_q : '0;

  assign bus.if_valid_o = (state_q == DONE) && !own_dm_q;
  assign bus.dm_valid_o = (state_q == DONE) && own_dm_q;
  assign bus.dm_err_o   = bus.dm_valid_o && err_q;
  assign bus.if_rdata_o = bus.if_valid_o ? rdata_q : '0;
  assign bus.dm_rdata_o = bus.dm_valid_o ? rdata_q : '0;

  assign bus.stallF_o = bus.if_req_i && !bus.if_valid_o;
  assign bus.stallM_o = bus.dm_req_i && !bus.dm_valid_o;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases plus randomized traffic
// against a byte-level memory reference model and a rule-level arbitration model.
module tb_mem_port_arbiter;
  localparam int MAX_D_BURST = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.XLEN(32)) bus ();

  mem_port_arbiter #(.XLEN(32), .MAX_D_BURST(MAX_D_BURST)) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Memory-side environment state
  int         ph = 0;
  int         gnt_left, rv_left;
  int         cfg_gnt_wait = 0, cfg_rv_wait = 0;
  bit         cfg_same = 1'b0;
  bit [31:0]  lat_addr, lat_wdata;
  bit [3:0]   lat_be;
  bit         lat_we;
  bit         chk_fields = 1'b0;
  bit [31:0]  exp_addr, exp_wdata;
  bit [3:0]   exp_be;
  bit         exp_we;
  bit         bus_used;
  bit         grant_log[$];
  bit [7:0]   env_mem[bit [31:0]];
  bit [7:0]   ref_mem[bit [31:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit [7:0] dflt(input bit [31:0] a);
    return 8'(a * 32'd13 + 32'd7);
  endfunction

  function automatic bit [7:0] env_rd(input bit [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : dflt(a);
  endfunction

  function automatic bit [7:0] ref_rd(input bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic bit [31:0] env_word(input bit [31:0] a);
    return {env_rd(a + 3), env_rd(a + 2), env_rd(a + 1), env_rd(a)};
  endfunction

  function automatic bit [31:0] ref_word(input bit [31:0] a);
    return {ref_rd(a + 3), ref_rd(a + 2), ref_rd(a + 1), ref_rd(a)};
  endfunction

  task automatic preload(input bit [31:0] a, input bit [31:0] w);
    for (int k = 0; k < 4; k++) begin
      env_mem[a + 32'(k)] = w[8*k +: 8];
      ref_mem[a + 32'(k)] = w[8*k +: 8];
    end
  endtask

  task automatic commit();
    if (lat_we)
      for (int k = 0; k < 4; k++)
        if (lat_be[k]) env_mem[lat_addr + 32'(k)] = lat_wdata[8*k +: 8];
  endtask

  task automatic reset_env();
    ph = 0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
  endtask

  // One clock of the memory model; observes and drives at the falling edge.
  task automatic tick();
    bit entered;
    @(negedge clk);
    entered = 1'b0;
    if (ph == 1 && bus.mem_gnt_i) begin
      if (bus.mem_rvalid_i) begin ph = 0; commit(); end
      else begin ph = 2; rv_left = cfg_rv_wait; end
    end else if (ph == 2 && bus.mem_rvalid_i) begin
      ph = 0; commit();
    end
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    if (bus.if_valid_o || bus.dm_valid_o)
      check("valid_exclusive", {31'd0, bus.if_valid_o & bus.dm_valid_o}, 32'd0);
    if (ph == 0 && bus.mem_req_o === 1'b1) begin
      ph = 1; entered = 1'b1; bus_used = 1'b1;
      lat_addr = bus.mem_addr_o; lat_be = bus.mem_be_o;
      lat_we = bus.mem_we_o; lat_wdata = bus.mem_wdata_o;
      gnt_left = cfg_gnt_wait;
      grant_log.push_back(bus.mem_addr_o >= 32'h8000);
      if (chk_fields) begin
        check("mem_addr", bus.mem_addr_o, exp_addr);
        check("mem_be", {28'd0, bus.mem_be_o}, {28'd0, exp_be});
        check("mem_we", {31'd0, bus.mem_we_o}, {31'd0, exp_we});
        if (exp_we) check("mem_wdata", bus.mem_wdata_o, exp_wdata);
      end
    end
    if (ph == 1) begin
      if (!entered) begin
        check("req_hold", {31'd0, bus.mem_req_o}, 32'd1);
        check("addr_stable", bus.mem_addr_o, lat_addr);
        check("be_we_stable", {27'd0, bus.mem_we_o, bus.mem_be_o}, {27'd0, lat_we, lat_be});
        check("wdata_stable", bus.mem_wdata_o, lat_wdata);
      end
      if (gnt_left == 0) begin
        bus.mem_gnt_i = 1'b1;
        if (cfg_same) begin
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i  = lat_we ? 32'd0 : env_word(lat_addr);
        end
      end else gnt_left--;
    end else if (ph == 2) begin
      if (rv_left == 0) begin
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = lat_we ? 32'd0 : env_word(lat_addr);
      end else rv_left--;
    end
  endtask

  task automatic data_txn(input bit we, input bit [1:0] size, input bit [31:0] addr,
                          input bit [31:0] wd, input int drop_at, input string tag);
    int nbytes, lane, exp_lat, n;
    bit mis, seen;
    bit [3:0] be;
    bit [31:0] wdr, exp_r, base;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    lane   = int'(addr % 4);
    base   = addr - 32'(lane);
    mis    = (addr % nbytes) != 0;
    be = '0; wdr = '0; exp_r = '0;
    for (int k = 0; k < 4; k++) begin
      be[k] = (k >= lane) && (k < lane + nbytes);
      wdr[8*k +: 8] = wd[8*(k % nbytes) +: 8];
    end
    if (!mis && we)
      for (int k = 0; k < nbytes; k++) ref_mem[addr + 32'(k)] = wd[8*k +: 8];
    if (!we)
      for (int k = 0; k < 4 - lane; k++) exp_r[8*k +: 8] = ref_rd(base + 32'(lane + k));
    exp_lat = mis ? 1 : cfg_same ? 2 + cfg_gnt_wait : 3 + cfg_gnt_wait + cfg_rv_wait;
    exp_addr = base; exp_be = be; exp_we = we; exp_wdata = wdr;
    chk_fields = 1'b1; bus_used = 1'b0;
    bus.dm_req_i = 1'b1; bus.dm_we_i = we; bus.dm_size_i = size;
    bus.dm_addr_i = addr; bus.dm_wdata_i = wd;
    seen = 1'b0; n = 0;
    while (!seen && n < 60) begin
      tick(); n++;
      check({tag, "_stallM"}, {31'd0, bus.stallM_o}, {31'd0, bus.dm_req_i && (n != exp_lat)});
      seen = bus.dm_valid_o;
      if (!seen && n == drop_at) bus.dm_req_i = 1'b0;
    end
    check({tag, "_latency"}, n, exp_lat);
    if (seen) begin
      check({tag, "_err"}, {31'd0, bus.dm_err_o}, {31'd0, mis});
      if (!mis) check({tag, "_rdata"}, bus.dm_rdata_o, exp_r);
    end
    check({tag, "_bus_used"}, {31'd0, bus_used}, {31'd0, !mis});
    chk_fields = 1'b0;
    bus.dm_req_i = 1'b0;
    tick();
    check({tag, "_pulse"}, {31'd0, bus.dm_valid_o}, 32'd0);
  endtask

  task automatic if_txn(input bit [31:0] addr, input string tag);
    int exp_lat, n;
    bit seen;
    exp_lat = cfg_same ? 2 + cfg_gnt_wait : 3 + cfg_gnt_wait + cfg_rv_wait;
    exp_addr = addr; exp_be = 4'b1111; exp_we = 1'b0; exp_wdata = '0;
    chk_fields = 1'b1;
    bus.if_req_i = 1'b1; bus.if_addr_i = addr;
    seen = 1'b0; n = 0;
    while (!seen && n < 60) begin
      tick(); n++;
      check({tag, "_stallF"}, {31'd0, bus.stallF_o}, {31'd0, n != exp_lat});
      seen = bus.if_valid_o;
    end
    check({tag, "_latency"}, n, exp_lat);
    if (seen) check({tag, "_rdata"}, bus.if_rdata_o, ref_word(addr));
    chk_fields = 1'b0;
    bus.if_req_i = 1'b0;
    tick();
    check({tag, "_pulse"}, {31'd0, bus.if_valid_o}, 32'd0);
  endtask

  initial begin
    int nvalid, streak;
    bit exp_if;
    bus.if_req_i = 1'b0; bus.if_addr_i = '0;
    bus.dm_req_i = 1'b0; bus.dm_we_i = 1'b0; bus.dm_size_i = 2'd0;
    bus.dm_addr_i = '0; bus.dm_wdata_i = '0;
    reset_env();

    // Reset state; stalls follow the requests even while held in reset
    repeat (2) @(negedge clk);
    check("rst_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
    check("rst_mem_be", {28'd0, bus.mem_be_o}, 32'd0);
    check("rst_mem_addr", bus.mem_addr_o, 32'd0);
    check("rst_valids", {30'd0, bus.if_valid_o, bus.dm_valid_o}, 32'd0);
    check("rst_err", {31'd0, bus.dm_err_o}, 32'd0);
    check("rst_stalls", {30'd0, bus.stallF_o, bus.stallM_o}, 32'd0);
    bus.if_req_i = 1'b1; bus.dm_req_i = 1'b1;
    #1;
    check("rst_stall_follow", {30'd0, bus.stallF_o, bus.stallM_o}, 32'd3);
    check("rst_no_req", {31'd0, bus.mem_req_o}, 32'd0);
    bus.if_req_i = 1'b0; bus.dm_req_i = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Directed cases
    preload(32'h100, 32'hDEADBEEF);
    preload(32'h10, 32'hABCD1234);
    data_txn(1'b0, 2'd2, 32'h100, 32'h0, -1, "lw");
    data_txn(1'b1, 2'd0, 32'h203, 32'h55, -1, "sb");
    data_txn(1'b0, 2'd1, 32'h12, 32'h0, -1, "lh");
    data_txn(1'b1, 2'd1, 32'h11, 32'h1234, -1, "sh_mis");
    data_txn(1'b0, 2'd2, 32'h202, 32'h0, -1, "lw_mis");
    data_txn(1'b0, 2'd2, 32'h200, 32'h0, -1, "lw_after_sb");
    cfg_gnt_wait = 5;
    data_txn(1'b1, 2'd2, 32'h20, 32'hCAFEF00D, -1, "sw_gnt5");
    cfg_gnt_wait = 0; cfg_same = 1'b1;
    data_txn(1'b0, 2'd3, 32'h20, 32'h0, -1, "lw_same");
    if_txn(32'h8000, "if_same");
    cfg_same = 1'b0; cfg_rv_wait = 2;
    data_txn(1'b0, 2'd0, 32'h23, 32'h0, 1, "lb_drop");
    cfg_rv_wait = 0;

    // Stray response while idle must be ignored
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h77777777;
    tick();
    check("stray_no_valid", {30'd0, bus.if_valid_o, bus.dm_valid_o}, 32'd0);
    tick();
    check("stray_no_req", {31'd0, bus.mem_req_o}, 32'd0);

    // Both requesters held: data wins until the burst limit lets fetch through
    grant_log.delete();
    bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_size_i = 2'd2; bus.dm_addr_i = 32'h40;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h8004;
    nvalid = 0;
    for (int c = 0; c < 200 && nvalid < 10; c++) begin
      tick();
      if (bus.if_valid_o || bus.dm_valid_o) nvalid++;
    end
    bus.dm_req_i = 1'b0; bus.if_req_i = 1'b0;
    check("arb_count", nvalid, 10);
    check("arb_log_size", grant_log.size(), 10);
    streak = 0;
    for (int k = 0; k < 10 && k < grant_log.size(); k++) begin
      exp_if = (streak == MAX_D_BURST);
      streak = exp_if ? 0 : streak + 1;
      check($sformatf("arb_order_%0d", k), {31'd0, grant_log[k]}, {31'd0, exp_if});
    end
    repeat (2) tick();

    // Reset while waiting for the response; the late response is ignored
    cfg_rv_wait = 5;
    bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_size_i = 2'd2; bus.dm_addr_i = 32'h100;
    repeat (2) tick();
    rstn = 1'b0; bus.dm_req_i = 1'b0;
    reset_env();
    #1;
    check("rstw_req", {31'd0, bus.mem_req_o}, 32'd0);
    check("rstw_valid", {31'd0, bus.dm_valid_o}, 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h12345678;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rstw_late_valid", {30'd0, bus.if_valid_o, bus.dm_valid_o}, 32'd0);
      check("rstw_late_req", {31'd0, bus.mem_req_o}, 32'd0);
      check("rstw_late_rdata", bus.dm_rdata_o, 32'd0);
    end

    // Reset while the request is waiting for a grant drops mem_req_o at once
    cfg_gnt_wait = 20; cfg_rv_wait = 0;
    bus.dm_req_i = 1'b1; bus.dm_addr_i = 32'h104;
    repeat (2) tick();
    check("rstr_req_before", {31'd0, bus.mem_req_o}, 32'd1);
    rstn = 1'b0; bus.dm_req_i = 1'b0;
    reset_env();
    #1;
    check("rstr_req_async", {31'd0, bus.mem_req_o}, 32'd0);
    tick();
    rstn = 1'b1;
    cfg_gnt_wait = 0;
    tick();
    data_txn(1'b0, 2'd2, 32'h100, 32'h0, -1, "lw_post_rst");

    // Randomized single-requester traffic
    for (int i = 0; i < 40; i++) begin
      cfg_gnt_wait = $urandom_range(0, 3);
      cfg_rv_wait  = $urandom_range(0, 3);
      cfg_same     = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0)
        if_txn(32'h8000 + 32'($urandom_range(0, 63)) * 4, $sformatf("rnd%0d_if", i));
      else
        data_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 32'($urandom_range(0, 63)), $urandom,
                 ($urandom_range(0, 4) == 0) ? 1 : -1, $sformatf("rnd%0d_dm", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
